// File: rtl/grant_mux_skid.sv
// Grant-driven payload mux feeding a 2-entry skid FIFO with a valid/ready output.
// The registered one-hot grant selects a requester; the accepted payload is acked and queued.
module grant_mux_skid #(
    parameter  int N  = 8,
    parameter  int W  = 32,
    localparam int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   grant,
    input  logic           grant_valid,
    input  logic [N*W-1:0] req_data,
    output logic [N-1:0]   ack,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_data,
    output logic [SW-1:0]  out_src,
    output logic           grant_err,
    output logic [1:0]     occupancy
);

    logic [W-1:0]  mem_data [2];
    logic [SW-1:0] mem_src  [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    occ;

    logic          onehot;
    logic          full;
    logic          accept;
    logic          pop;
    logic [W-1:0]  sel_data;
    logic [SW-1:0] sel_src;

    always_comb begin
        onehot = (grant != '0) && ((grant & (grant - N'(1))) == '0);
        // Full uses the registered count, so a same-cycle pop does not free a slot.
        full   = (occ == 2'd2);
        accept = grant_valid && onehot && !full && !reset;
        pop    = (occ != 2'd0) && out_ready;
        ack    = accept ? grant : '0;
    end

    always_comb begin
        sel_data = '0;
        sel_src  = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                sel_data = req_data[i*W +: W];
                sel_src  = SW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            occ         <= 2'd0;
            grant_err   <= 1'b0;
            mem_data[0] <= '0;
            mem_data[1] <= '0;
            mem_src[0]  <= '0;
            mem_src[1]  <= '0;
        end else begin
            if (accept) begin
                mem_data[wr_ptr] <= sel_data;
                mem_src[wr_ptr]  <= sel_src;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({accept, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
            // Multi-hot grant is an arbiter fault; latch it until reset.
            if (grant_valid && (grant != '0) && !onehot) begin
                grant_err <= 1'b1;
            end
        end
    end

    assign out_valid = (occ != 2'd0);
    assign out_data  = mem_data[rd_ptr];
    assign out_src   = mem_src[rd_ptr];
    assign occupancy = occ;

endmodule

// File: tb/tb_grant_mux_skid.sv
// Bench for grant_mux_skid: directed cycle table followed by randomized traffic
// checked against a queue-based reference model.
module tb_grant_mux_skid;

    localparam int N  = 8;
    localparam int W  = 32;
    localparam int SW = 3;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   grant;
    logic           grant_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   ack;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_src;
    logic           grant_err;
    logic [1:0]     occupancy;

    grant_mux_skid #(.N(N), .W(W)) dut (
        .clk(clk), .reset(reset), .grant(grant), .grant_valid(grant_valid),
        .req_data(req_data), .ack(ack), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_src(out_src), .grant_err(grant_err), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Handshake invariants, evaluated every cycle at the negedge.
    logic          hold_prev = 1'b0;
    logic [W-1:0]  prev_data;
    logic [SW-1:0] prev_src;

    task automatic chk_invariants();
        chk("ack_onehot0", 64'($onehot0(ack)), 64'd1);
        chk("occ_le_2", 64'(occupancy <= 2'd2), 64'd1);
        if (hold_prev) begin
            chk("bp_valid_held", 64'(out_valid), 64'd1);
            chk("bp_data_stable", 64'(out_data), 64'(prev_data));
            chk("bp_src_stable", 64'(out_src), 64'(prev_src));
        end
        hold_prev = out_valid && !out_ready && !reset;
        prev_data = out_data;
        prev_src  = out_src;
    endtask

    task automatic drive(input logic r, input logic gv, input logic [N-1:0] g, input logic rdy);
        reset       = r;
        grant_valid = gv;
        grant       = g;
        out_ready   = rdy;
        @(negedge clk);
    endtask

    typedef struct {
        logic         rst;
        logic         gv;
        logic [N-1:0] g;
        logic         rdy;
        logic [N-1:0] ack;
        logic         vld;
        logic [SW-1:0] src;
        logic [1:0]   occ;
        logic         err;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic gv, input logic [N-1:0] g,
                                input logic rdy, input logic [N-1:0] a, input logic vld,
                                input logic [SW-1:0] src, input logic [1:0] occ, input logic err);
        vec_t v;
        v.rst = rst; v.gv = gv; v.g = g; v.rdy = rdy; v.ack = a;
        v.vld = vld; v.src = src; v.occ = occ; v.err = err;
        return v;
    endfunction

    // Reference model state
    typedef struct {
        logic [W-1:0]  data;
        logic [SW-1:0] src;
    } entry_t;
    entry_t q[$];
    logic   m_err;

    function automatic int bit_index(input logic [N-1:0] g);
        for (int i = 0; i < N; i++) if (g[i]) return i;
        return 0;
    endfunction

    vec_t tbl[27];

    initial begin
        reset = 1'b1; grant_valid = 1'b0; grant = '0; out_ready = 1'b1;
        for (int i = 0; i < N; i++) req_data[i*W +: W] = 32'hA5A5_0000 + 32'(i);
        repeat (2) @(posedge clk);
        #1;

        //         rst gv  grant       rdy ack         vld src occ err
        // single transfer
        tbl[0]  = mk(1, 0, 8'h00, 1, 8'h00, 0, 0, 0, 0);
        tbl[1]  = mk(0, 1, 8'h20, 1, 8'h20, 0, 0, 0, 0);
        tbl[2]  = mk(0, 0, 8'h00, 1, 8'h00, 1, 5, 1, 0);
        tbl[3]  = mk(0, 0, 8'h00, 1, 8'h00, 0, 0, 0, 0);
        // backpressure until full, then drain with retried grant to 1
        tbl[4]  = mk(0, 1, 8'h08, 0, 8'h08, 0, 0, 0, 0);
        tbl[5]  = mk(0, 1, 8'h40, 0, 8'h40, 1, 3, 1, 0);
        tbl[6]  = mk(0, 1, 8'h02, 0, 8'h00, 1, 3, 2, 0);
        tbl[7]  = mk(0, 1, 8'h02, 0, 8'h00, 1, 3, 2, 0);
        tbl[8]  = mk(0, 1, 8'h02, 1, 8'h00, 1, 3, 2, 0);
        tbl[9]  = mk(0, 1, 8'h02, 1, 8'h02, 1, 6, 1, 0);
        tbl[10] = mk(0, 0, 8'h00, 1, 8'h00, 1, 1, 1, 0);
        tbl[11] = mk(0, 0, 8'h00, 1, 8'h00, 0, 0, 0, 0);
        // streaming push+pop at occupancy 1
        tbl[12] = mk(0, 1, 8'h01, 1, 8'h01, 0, 0, 0, 0);
        tbl[13] = mk(0, 1, 8'h04, 1, 8'h04, 1, 0, 1, 0);
        tbl[14] = mk(0, 1, 8'h80, 1, 8'h80, 1, 2, 1, 0);
        tbl[15] = mk(0, 0, 8'h00, 1, 8'h00, 1, 7, 1, 0);
        tbl[16] = mk(0, 0, 8'h00, 1, 8'h00, 0, 0, 0, 0);
        // zero and multi-hot grants
        tbl[17] = mk(0, 1, 8'h00, 1, 8'h00, 0, 0, 0, 0);
        tbl[18] = mk(0, 1, 8'h81, 1, 8'h00, 0, 0, 0, 0);
        tbl[19] = mk(0, 0, 8'h81, 1, 8'h00, 0, 0, 0, 1);
        tbl[20] = mk(0, 1, 8'h10, 1, 8'h10, 0, 0, 0, 1);
        tbl[21] = mk(0, 0, 8'h00, 1, 8'h00, 1, 4, 1, 1);
        tbl[22] = mk(0, 0, 8'h00, 1, 8'h00, 0, 0, 0, 1);
        // reset while full with an active grant
        tbl[23] = mk(0, 1, 8'h01, 0, 8'h01, 0, 0, 0, 1);
        tbl[24] = mk(0, 1, 8'h02, 0, 8'h02, 1, 0, 1, 1);
        tbl[25] = mk(1, 1, 8'h04, 0, 8'h00, 1, 0, 2, 1);
        tbl[26] = mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0);

        foreach (tbl[k]) begin
            drive(tbl[k].rst, tbl[k].gv, tbl[k].g, tbl[k].rdy);
            chk($sformatf("t%0d_ack", k), 64'(ack), 64'(tbl[k].ack));
            chk($sformatf("t%0d_valid", k), 64'(out_valid), 64'(tbl[k].vld));
            chk($sformatf("t%0d_occ", k), 64'(occupancy), 64'(tbl[k].occ));
            chk($sformatf("t%0d_err", k), 64'(grant_err), 64'(tbl[k].err));
            if (tbl[k].vld) begin
                chk($sformatf("t%0d_src", k), 64'(out_src), 64'(tbl[k].src));
                chk($sformatf("t%0d_data", k), 64'(out_data), 64'(32'hA5A5_0000 + 32'(tbl[k].src)));
            end
            chk_invariants();
            @(posedge clk);
            #1;
        end

        // Randomized traffic against the queue model
        drive(1, 0, '0, 1);
        chk_invariants();
        @(posedge clk);
        #1;
        q.delete();
        m_err = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            logic         r, gv, rdy, acc;
            logic [N-1:0] g;
            int           sel;
            r   = ($urandom_range(0, 499) == 0);
            gv  = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            sel = $urandom_range(0, 39);
            if (sel == 0)      g = '0;
            else if (sel == 1) g = N'($urandom) | N'(8'h11);
            else               g = N'(1) << $urandom_range(0, N-1);
            for (int i = 0; i < N; i++) req_data[i*W +: W] = $urandom;
            drive(r, gv, g, rdy);

            acc = gv && ($countones(g) == 1) && (q.size() < 2) && !r;
            chk("rnd_ack", 64'(ack), acc ? 64'(g) : 64'd0);
            chk("rnd_valid", 64'(out_valid), 64'(q.size() != 0));
            chk("rnd_occ", 64'(occupancy), 64'(q.size()));
            chk("rnd_err", 64'(grant_err), 64'(m_err));
            if (q.size() != 0) begin
                chk("rnd_data", 64'(out_data), 64'(q[0].data));
                chk("rnd_src", 64'(out_src), 64'(q[0].src));
            end
            chk_invariants();

            if (r) begin
                q.delete();
                m_err = 1'b0;
            end else begin
                if (q.size() != 0 && rdy) void'(q.pop_front());
                if (acc) begin
                    entry_t e;
                    e.src  = SW'(bit_index(g));
                    e.data = req_data[bit_index(g)*W +: W];
                    q.push_back(e);
                end
                if (gv && ($countones(g) > 1)) m_err = 1'b1;
            end
            @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/grant_mux_skid.md
Name: grant_mux_skid

Overview:
- Downstream consumer of the priority arbiter's registered one-hot grant.
- Uses grant/grant_valid to select one requester's payload, acknowledges the winner, and buffers the result in a 2-entry skid FIFO.
- The FIFO feeds a valid/ready output channel.
- Unacknowledged requesters keep req asserted, so the arbiter retries them naturally.

Parameters:
- N, 8, number of requesters; must match the arbiter's N, N >= 2.
- W, 32, payload width per requester.
- SW, $clog2(N), source-index width (derived; not overridden).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- grant  input  N  one-hot grant from arbiter (registered there)
- grant_valid  input  1  grant qualifier from arbiter
- req_data  input  N*W  flat payloads; requester i occupies bits [i*W +: W]
- ack  output  N  one-hot, combinational; pulses for the cycle in which requester i's payload is captured
- out_valid  output  1  head entry valid
- out_ready  input  1  downstream ready
- out_data  output  W  head payload
- out_src  output  SW  binary index of head entry's requester
- grant_err  output  1  sticky; set on a multi-hot grant
- occupancy  output  2  entries held (0..2)

Behaviour:
- Reset: all of the following clear at the next clk edge while reset = 1, and reset overrides any push/pop in that cycle.
  - out_valid = 0, out_data = 0, out_src = 0
  - grant_err = 0, occupancy = 0
  - FIFO pointers = 0, ack = 0
- onehot = grant != 0 && (grant & (grant - 1)) == 0.
- full = (occupancy == 2), using the registered count.
- accept = grant_valid && onehot && !full && !reset.
- ack = accept ? grant : 0. Combinational, same cycle as accept; no ack otherwise.
- Push on accept:
  - entry stores req_data slice of the granted index, plus its binary index (priority encode of grant).
  - data is sampled in the accept cycle.
- Pop when out_valid && out_ready.
- Handshake:
  - out_data/out_src must stay stable while out_valid && !out_ready.
  - out_valid never drops without a pop.
- Latency:
  - accept in cycle t -> out_valid = 1 in cycle t+1 if the FIFO was empty.
  - otherwise the entry appears after all older entries; strict FIFO order.
- Occupancy update: push only +1, pop only -1, both -> unchanged.
- Full: no push even if a pop happens in the same cycle (full is evaluated on the registered count). The grant is dropped with no ack, costing one bubble; this is intended.
- Empty: out_valid = 0, out_data/out_src hold the last value (don't-care for the checker). A pop cannot occur.
- grant_valid with grant = 0: ignored, no ack, no error.
- grant_valid with multi-hot grant: no accept, no ack; grant_err <= 1 and stays set until reset.
- grant_valid = 0: grant is ignored regardless of value, with no error check.
- Pointers: 1-bit write/read pointers wrapping 1 -> 0; occupancy is the separate 2-bit counter.
- Reset mid-operation: buffered entries are discarded, no acks are issued, and out_valid = 0 on the cycle after the reset edge.
- Assertions in the bench:
  - ack is onehot0.
  - occupancy <= 2.
  - out_data stable under backpressure.

Test Plan:
1. Single transfer, N=8, W=32: reset, out_ready = 1; cycle t: grant = 8'b0010_0000, grant_valid = 1, req_data[5] = 32'hA5A5_0005 -> ack = 8'b0010_0000 at t; out_valid = 1, out_data = 32'hA5A5_0005, out_src = 5 at t+1; occupancy back to 0 at t+2.
2. Backpressure/full: out_ready = 0; grants to 3 then 6 on consecutive cycles, then a grant to 1 -> acks for 3 and 6 only; occupancy = 2; no ack for 1; out_data = req 3 payload, stable. Raise out_ready -> pops 3 then 6 in order; the retried grant to 1 is accepted once not full.
3. Simultaneous push/pop at occupancy 1, out_ready = 1, continuous grants -> occupancy stays 1; one output per cycle; sources in grant order.
4. Bad grants: grant_valid = 1 with grant = 0 -> no ack, no error. grant = 8'b1000_0001 -> no ack, grant_err = 1 next cycle and held until reset.
5. Reset mid-operation: occupancy = 2, assert reset for 1 cycle during an active grant -> ack = 0 that cycle; next cycle out_valid = 0, occupancy = 0, grant_err = 0.
6. Random stress: random one-hot grants/valid/out_ready for 10k cycles against a scoreboard queue -> no loss, no duplication, order preserved, acks match the scoreboard pushes.
